// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter bank.
package counter_pkg;

   localparam int   COUNT_INIT    = 1;
   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

   // Index width that never collapses to zero bits for a single channel.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(n)) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/counter_bank_channel.sv
// One enable-gated period counter with run control, one-shot mode and a
// shadowed period that only takes effect on a period boundary.
module counter_bank_channel
   import counter_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_en,
   input  logic             run_set,
   input  logic             run_clr,
   input  logic             cfg_we,
   input  logic [WIDTH-1:0] cfg_period,
   input  logic             cfg_oneshot,
   output logic             running,
   output logic             pending,
   output logic             strobe
);

   localparam logic [WIDTH-1:0] INIT = WIDTH'(COUNT_INIT);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] active_q, active_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             mode_q, mode_d;
   logic             smode_q, smode_d;
   logic             running_q, running_d;
   logic             pending_q, pending_d;
   logic             strobe_q, strobe_d;
   logic             term;

   always_comb begin
      term      = running_q & tick_en & (count_q == active_q);
      count_d   = count_q;
      active_d  = active_q;
      shadow_d  = shadow_q;
      mode_d    = mode_q;
      smode_d   = smode_q;
      running_d = running_q;
      pending_d = pending_q;
      strobe_d  = term & ~run_clr;

      if (run_clr || run_set || term) begin
         count_d = INIT;
      end else if (running_q && tick_en) begin
         count_d = count_q + WIDTH'(1);
      end

      if (run_clr) begin
         running_d = 1'b0;
      end else if (run_set) begin
         running_d = 1'b1;
      end else if (term && (mode_q == MODE_ONESHOT)) begin
         running_d = 1'b0;
      end

      if (cfg_we) begin
         shadow_d = cfg_period;
         smode_d  = cfg_oneshot;
      end

      // Shadow goes live only where no period is in progress: idle, wrap, or restart.
      if ((cfg_we || pending_q) && (!running_q || term || run_set || run_clr)) begin
         active_d  = shadow_d;
         mode_d    = smode_d;
         pending_d = 1'b0;
      end else if (cfg_we) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= INIT;
         active_q  <= INIT;
         shadow_q  <= INIT;
         mode_q    <= MODE_PERIODIC;
         smode_q   <= MODE_PERIODIC;
         running_q <= 1'b0;
         pending_q <= 1'b0;
         strobe_q  <= 1'b0;
      end else begin
         count_q   <= count_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         mode_q    <= mode_d;
         smode_q   <= smode_d;
         running_q <= running_d;
         pending_q <= pending_d;
         strobe_q  <= strobe_d;
      end
   end

   assign running = running_q;
   assign pending = pending_q;
   assign strobe  = strobe_q;

endmodule

// File: rtl/counter_bank_strobe.sv
// Bank of independent period counters with validated config writes and a
// merged any/lowest-index summary of the registered strobes.
module counter_bank_strobe
   import counter_pkg::*;
#(
   parameter  int CHANNELS = 4,
   parameter  int WIDTH    = 16,
   localparam int CH_BITS  = clog2_min1(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] tick_en,
   input  logic [CHANNELS-1:0] run_set,
   input  logic [CHANNELS-1:0] run_clr,
   input  logic                cfg_we,
   input  logic [CH_BITS-1:0]  cfg_ch,
   input  logic [WIDTH-1:0]    cfg_period,
   input  logic                cfg_oneshot,
   output logic                cfg_err,
   output logic [CHANNELS-1:0] running,
   output logic [CHANNELS-1:0] pending,
   output logic [CHANNELS-1:0] strobe,
   output logic                strobe_any,
   output logic [CH_BITS-1:0]  strobe_idx
);

   localparam logic [CH_BITS:0] CH_LIMIT = (CH_BITS + 1)'(CHANNELS);

   logic cfg_ok;
   logic cfg_err_q, cfg_err_d;

   assign cfg_ok    = cfg_we && (cfg_period != '0) && ({1'b0, cfg_ch} < CH_LIMIT);
   assign cfg_err_d = cfg_we && !cfg_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= cfg_err_d;
      end
   end

   assign cfg_err = cfg_err_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      counter_bank_channel #(
         .WIDTH(WIDTH)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .tick_en    (tick_en[i]),
         .run_set    (run_set[i]),
         .run_clr    (run_clr[i]),
         .cfg_we     (cfg_ok && (cfg_ch == CH_BITS'(i))),
         .cfg_period (cfg_period),
         .cfg_oneshot(cfg_oneshot),
         .running    (running[i]),
         .pending    (pending[i]),
         .strobe     (strobe[i])
      );
   end

   assign strobe_any = |strobe;

   // Scan from the top so the lowest set index is the last one written.
   always_comb begin
      strobe_idx = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (strobe[i]) strobe_idx = CH_BITS'(i);
      end
   end

endmodule

// File: tb/tb_counter_bank_strobe.sv
// Scoreboarded bench for counter_bank_strobe: expected strobe events are queued
// with their cycle number as stimulus is issued and retired by a strobe monitor.
module tb_counter_bank_strobe;

   logic        clk;
   logic        rst;
   logic [3:0]  tick_en;
   logic [3:0]  run_set;
   logic [3:0]  run_clr;
   logic        cfg_we;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_period;
   logic        cfg_oneshot;
   logic        cfg_err;
   logic [3:0]  running;
   logic [3:0]  pending;
   logic [3:0]  strobe;
   logic        strobe_any;
   logic [1:0]  strobe_idx;

   typedef struct {
      int         cyc;
      logic [3:0] mask;
      logic [1:0] idx;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   counter_bank_strobe #(
      .CHANNELS(4),
      .WIDTH   (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick_en    (tick_en),
      .run_set    (run_set),
      .run_clr    (run_clr),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_period (cfg_period),
      .cfg_oneshot(cfg_oneshot),
      .cfg_err    (cfg_err),
      .running    (running),
      .pending    (pending),
      .strobe     (strobe),
      .strobe_any (strobe_any),
      .strobe_idx (strobe_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Strobe monitor: every strobe must match a queued event for this cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         n_checks++;
         if (strobe !== e.mask || strobe_any !== 1'b1 || strobe_idx !== e.idx) begin
            n_fail++;
            $display("FAIL strobe_event cyc=%0d got strobe=%b any=%b idx=%0d want strobe=%b any=1 idx=%0d",
                     cyc, strobe, strobe_any, strobe_idx, e.mask, e.idx);
         end
      end else if (strobe !== 4'b0000 || strobe_any !== 1'b0 || strobe_idx !== 2'd0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_strobe cyc=%0d got strobe=%b any=%b idx=%0d want all zero",
                  cyc, strobe, strobe_any, strobe_idx);
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout cyc=%0d got no completion want completion", cyc);
      $fatal(1, "bench timeout");
   end

   task automatic to_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic cfg_write(input int ch, input int p, input logic os);
      cfg_we      = 1'b1;
      cfg_ch      = 2'(ch);
      cfg_period  = 16'(p);
      cfg_oneshot = os;
      @(negedge clk);
      cfg_we      = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (strobe !== 4'b0 || running !== 4'b0 || pending !== 4'b0 || cfg_err !== 1'b0 ||
          strobe_any !== 1'b0 || strobe_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state got strobe=%b run=%b pend=%b err=%b any=%b idx=%0d want all zero",
                  strobe, running, pending, cfg_err, strobe_any, strobe_idx);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_periodic();
      int r;
      cfg_write(0, 5, 1'b0);
      n_checks++;
      if (cfg_err !== 1'b0 || pending[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL periodic_cfg got err=%b pend=%b want err=0 pend=0", cfg_err, pending[0]);
      end
      run_set    = 4'b0001;
      tick_en[0] = 1'b1;
      r = cyc + 1;
      sb.push_back('{r + 5,  4'b0001, 2'd0});
      sb.push_back('{r + 10, 4'b0001, 2'd0});
      sb.push_back('{r + 15, 4'b0001, 2'd0});
      @(negedge clk);
      run_set = 4'b0000;
      to_cyc(r + 16);
      n_checks++;
      if (running[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL periodic_running got %b want 1", running[0]);
      end
      run_clr = 4'b0001;
      @(negedge clk);
      run_clr    = 4'b0000;
      tick_en[0] = 1'b0;
      n_checks++;
      if (running[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL periodic_stop got %b want 0", running[0]);
      end
   endtask

   task automatic test_gated();
      int r;
      cfg_write(1, 3, 1'b0);
      run_set    = 4'b0010;
      tick_en[1] = 1'b0;
      r = cyc + 1;
      sb.push_back('{r + 5,  4'b0010, 2'd1});
      sb.push_back('{r + 11, 4'b0010, 2'd1});
      sb.push_back('{r + 17, 4'b0010, 2'd1});
      @(negedge clk);
      run_set = 4'b0000;
      for (int j = 0; j < 20; j++) begin
         tick_en[1] = (j % 2 == 0);
         @(negedge clk);
      end
      run_clr = 4'b0010;
      @(negedge clk);
      run_clr    = 4'b0000;
      tick_en[1] = 1'b0;
   endtask

   task automatic test_oneshot();
      int r;
      cfg_write(2, 4, 1'b1);
      run_set    = 4'b0100;
      tick_en[2] = 1'b1;
      r = cyc + 1;
      sb.push_back('{r + 4, 4'b0100, 2'd2});
      @(negedge clk);
      run_set = 4'b0000;
      to_cyc(r + 3);
      n_checks++;
      if (running[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL oneshot_before got %b want 1", running[2]);
      end
      to_cyc(r + 4);
      n_checks++;
      if (running[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL oneshot_fall got %b want 0", running[2]);
      end
      to_cyc(r + 24);
      n_checks++;
      if (running[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL oneshot_idle got %b want 0", running[2]);
      end
      tick_en[2] = 1'b0;
   endtask

   task automatic test_shadow();
      int r;
      cfg_write(0, 8, 1'b0);
      run_set    = 4'b0001;
      tick_en[0] = 1'b1;
      r = cyc + 1;
      sb.push_back('{r + 8,  4'b0001, 2'd0});
      sb.push_back('{r + 10, 4'b0001, 2'd0});
      sb.push_back('{r + 12, 4'b0001, 2'd0});
      sb.push_back('{r + 14, 4'b0001, 2'd0});
      @(negedge clk);
      run_set = 4'b0000;
      to_cyc(r + 2);
      cfg_write(0, 2, 1'b0);
      n_checks++;
      if (pending[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL shadow_pending_set got %b want 1", pending[0]);
      end
      to_cyc(r + 7);
      n_checks++;
      if (pending[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL shadow_pending_hold got %b want 1", pending[0]);
      end
      to_cyc(r + 8);
      n_checks++;
      if (pending[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL shadow_pending_clear got %b want 0", pending[0]);
      end
      to_cyc(r + 14);
      run_clr = 4'b0001;
      @(negedge clk);
      run_clr    = 4'b0000;
      tick_en[0] = 1'b0;
   endtask

   task automatic test_collisions();
      int r;
      cfg_write(3, 2, 1'b0);
      run_set    = 4'b1000;
      tick_en[3] = 1'b1;
      r = cyc + 1;
      @(negedge clk);
      run_set = 4'b0000;
      to_cyc(r + 1);
      run_clr = 4'b1000;
      @(negedge clk);
      run_clr    = 4'b0000;
      tick_en[3] = 1'b0;
      n_checks++;
      if (running[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_on_terminal_running got %b want 0", running[3]);
      end

      cfg_write(3, 0, 1'b1);
      n_checks++;
      if (cfg_err !== 1'b1 || pending[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_zero_err got err=%b pend=%b want err=1 pend=0", cfg_err, pending[3]);
      end
      @(negedge clk);
      n_checks++;
      if (cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_err_pulse got %b want 0", cfg_err);
      end

      // ch3 must still count period 2 after the rejected write.
      cfg_write(1, 2, 1'b0);
      run_set = 4'b1010;
      tick_en = 4'b1010;
      r = cyc + 1;
      sb.push_back('{r + 2, 4'b1010, 2'd1});
      sb.push_back('{r + 4, 4'b1010, 2'd1});
      @(negedge clk);
      run_set = 4'b0000;
      to_cyc(r + 4);
      run_clr = 4'b1010;
      @(negedge clk);
      run_clr = 4'b0000;
      tick_en = 4'b0000;
      n_checks++;
      if (running !== 4'b0000) begin
         n_fail++;
         $display("FAIL collision_stop got %b want 0000", running);
      end
   endtask

   task automatic test_back_to_back();
      int r;
      cfg_write(2, 1, 1'b0);
      run_set    = 4'b0100;
      tick_en[2] = 1'b1;
      r = cyc + 1;
      sb.push_back('{r + 1, 4'b0100, 2'd2});
      sb.push_back('{r + 2, 4'b0100, 2'd2});
      sb.push_back('{r + 3, 4'b0100, 2'd2});
      @(negedge clk);
      run_set = 4'b0000;
      to_cyc(r + 3);
      run_clr = 4'b0100;
      @(negedge clk);
      run_clr    = 4'b0000;
      tick_en[2] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int r;
      cfg_write(0, 3, 1'b0);
      run_set    = 4'b0001;
      tick_en[0] = 1'b1;
      r = cyc + 1;
      @(negedge clk);
      run_set = 4'b0000;
      to_cyc(r + 2);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (strobe !== 4'b0 || running !== 4'b0 || pending !== 4'b0 || cfg_err !== 1'b0 ||
          strobe_any !== 1'b0 || strobe_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid got strobe=%b run=%b pend=%b err=%b any=%b idx=%0d want all zero",
                  strobe, running, pending, cfg_err, strobe_any, strobe_idx);
      end
      rst        = 1'b0;
      tick_en[0] = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++;
      if (running !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_mid_after got %b want 0000", running);
      end
   endtask

   initial begin
      rst         = 1'b1;
      tick_en     = '0;
      run_set     = '0;
      run_clr     = '0;
      cfg_we      = 1'b0;
      cfg_ch      = '0;
      cfg_period  = '0;
      cfg_oneshot = 1'b0;
      @(negedge clk);
      test_reset();
      test_periodic();
      test_gated();
      test_oneshot();
      test_shadow();
      test_collisions();
      test_back_to_back();
      test_reset_mid();
      repeat (3) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
